// File: rtl/cmd_queue.sv
// cmd_queue: FIFO between the USB command decoder and the phase generator.
// Handles in-band flush and status opcodes, which are answered on the reply port and never queued.
module cmd_queue #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [7:0]  FLUSH_OP   = 8'hFF,
    parameter logic [7:0]  STATUS_OP  = 8'hFE
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_command,
    input  logic [23:0]           i_command_data,
    input  logic                  i_ready,
    output logic                  o_command,
    output logic [23:0]           o_command_data,
    output logic                  o_overflow,
    output logic                  o_reply,
    output logic [23:0]           o_reply_data,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_empty
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [23:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          cmd_q, cmd_d, reply_q, reply_d;
    logic [23:0]   cmd_data_q, cmd_data_d, reply_data_q, reply_data_d;
    logic          is_flush, is_status, is_data, full, deq, wr, drop;
    logic [15:0]   status_lo;

    assign is_flush  = i_command && (i_command_data[23:16] == FLUSH_OP);
    assign is_status = i_command && (i_command_data[23:16] == STATUS_OP);
    assign is_data   = i_command && !is_flush && !is_status;
    assign full      = level_q == LW'(DEPTH);
    assign deq       = (level_q != '0) && i_ready && !is_flush;
    // A full queue still accepts a write when a slot frees up in the same cycle
    assign wr        = is_data && (!full || deq);
    assign drop      = is_data && full && !deq;

    always_comb begin
        status_lo                = '0;
        status_lo[DEPTH_LOG2:0]  = level_q;
        status_lo[15]            = overflow_q;
        wr_ptr_d     = is_flush ? '0 : wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = is_flush ? '0 : deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d      = is_flush ? '0 : level_q + LW'(wr) - LW'(deq);
        overflow_d   = !is_flush && (overflow_q || drop);
        cmd_d        = deq;
        cmd_data_d   = deq ? mem_q[rd_ptr_q] : cmd_data_q;
        reply_d      = is_flush || is_status;
        reply_data_d = is_flush  ? {FLUSH_OP, 16'h0000} :
                       is_status ? {STATUS_OP, status_lo} : reply_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (wr) mem_q[wr_ptr_q] <= i_command_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            cmd_q        <= 1'b0;
            cmd_data_q   <= '0;
            reply_q      <= 1'b0;
            reply_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            cmd_q        <= cmd_d;
            cmd_data_q   <= cmd_data_d;
            reply_q      <= reply_d;
            reply_data_q <= reply_data_d;
        end
    end

    assign o_command      = cmd_q;
    assign o_command_data = cmd_data_q;
    assign o_overflow     = overflow_q;
    assign o_reply        = reply_q;
    assign o_reply_data   = reply_data_q;
    assign o_level        = level_q;
    assign o_empty        = level_q == '0;
endmodule

// File: tb/tb_cmd_queue.sv
// tb_cmd_queue: directed scoreboard bench for cmd_queue.
module tb_cmd_queue;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_command = 1'b0;
    logic [23:0] i_command_data = 24'hFF0000;
    logic        i_ready = 1'b0;
    logic        o_command, o_overflow, o_reply, o_empty;
    logic [23:0] o_command_data, o_reply_data;
    logic [4:0]  o_level;

    int checks = 0;
    int errors = 0;
    logic [23:0] exp_cmd[$];
    logic [23:0] exp_reply[$];

    cmd_queue dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_command(i_command),
        .i_command_data(i_command_data), .i_ready(i_ready),
        .o_command(o_command), .o_command_data(o_command_data),
        .o_overflow(o_overflow), .o_reply(o_reply), .o_reply_data(o_reply_data),
        .o_level(o_level), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called right after a falling edge; returns after the next falling edge.
    // Idle data carries the flush opcode so a DUT that ignores i_command would misbehave.
    task automatic send(input logic [23:0] d);
        i_command = 1'b1;
        i_command_data = d;
        @(negedge i_clk);
        i_command = 1'b0;
        i_command_data = 24'hFF0000;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_cmd.size() != 0 || o_level != 0) && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        @(negedge i_clk);
        chk({name, "_drain_timeout"}, n < 100, 1);
    endtask

    task automatic monitor();
        forever begin
            @(negedge i_clk);
            if (o_command) begin
                if (exp_cmd.size() == 0) chk("unexpected_command", o_command_data, 32'hDEAD);
                else chk("cmd_data", o_command_data, exp_cmd.pop_front());
            end
            if (o_reply) begin
                if (exp_reply.size() == 0) chk("unexpected_reply", o_reply_data, 32'hDEAD);
                else chk("reply_data", o_reply_data, exp_reply.pop_front());
            end
        end
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'hB6D7;
        fork
            monitor();
        join_none
        #2;
        chk("rst_level", o_level, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_command", o_command, 0);
        chk("rst_reply", o_reply, 0);
        chk("rst_cmd_data", o_command_data, 0);
        chk("rst_reply_data", o_reply_data, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Single word, minimum latency of two edges
        i_ready = 1'b1;
        exp_cmd.push_back(24'h010203);
        send(24'h010203);
        chk("lat_not_yet", o_command, 0);
        chk("lat_level1", o_level, 1);
        @(negedge i_clk);
        chk("lat_issue", o_command, 1);
        chk("lat_data", o_command_data, 24'h010203);
        chk("lat_level0", o_level, 0);
        @(negedge i_clk);
        chk("lat_single_pulse", o_command, 0);
        chk("lat_hold_data", o_command_data, 24'h010203);

        // Overflow: 17 words into 16 slots, the 17th is dropped
        i_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 16) exp_cmd.push_back(24'(i));
            send(24'(i));
        end
        chk("ovf_level", o_level, 16);
        chk("ovf_flag", o_overflow, 1);
        chk("ovf_not_empty", o_empty, 0);
        i_ready = 1'b1;
        drain("ovf");
        chk("ovf_sticky", o_overflow, 1);
        chk("ovf_empty", o_empty, 1);
        exp_reply.push_back(24'hFF0000);
        send(24'hFF0000);
        chk("flush_clears_ovf", o_overflow, 0);

        // Write into a full queue during a dequeue is accepted
        i_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_cmd.push_back(24'h100 + 24'(i));
            send(24'h100 + 24'(i));
        end
        chk("full_level", o_level, 16);
        i_ready = 1'b1;
        exp_cmd.push_back(24'h0000AA);
        send(24'h0000AA);
        chk("full_wr_level", o_level, 16);
        chk("full_wr_no_ovf", o_overflow, 0);
        drain("full");
        chk("full_no_ovf_end", o_overflow, 0);

        // Status and flush with five queued and overflow set
        i_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            if (i <= 11) exp_cmd.push_back(24'h200 + 24'(i));
            send(24'h200 + 24'(i));
        end
        i_ready = 1'b1;
        repeat (11) @(negedge i_clk);
        i_ready = 1'b0;
        chk("stat_level5", o_level, 5);
        exp_reply.push_back(24'hFE8005);
        send(24'hFE0000);
        chk("stat_level_kept", o_level, 5);
        chk("stat_ovf_kept", o_overflow, 1);
        chk("stat_reply_strobe", o_reply, 1);
        exp_reply.push_back(24'hFF0000);
        send(24'hFF0000);
        chk("flush_level", o_level, 0);
        chk("flush_ovf", o_overflow, 0);
        chk("flush_empty", o_empty, 1);
        @(negedge i_clk);
        chk("reply_hold", o_reply_data, 24'hFF0000);

        // Status in the same cycle as a dequeue reports the pre-edge level
        exp_cmd.push_back(24'h0A0A0A);
        exp_cmd.push_back(24'h0B0B0B);
        send(24'h0A0A0A);
        send(24'h0B0B0B);
        i_ready = 1'b1;
        exp_reply.push_back(24'hFE0002);
        send(24'hFE1234);
        chk("stat_deq_level", o_level, 1);
        drain("stat_deq");

        // 40 words with a fixed irregular ready pattern, wrapping the pointers
        for (int i = 0; i < 40; i++) begin
            i_ready = pat[i % 16];
            exp_cmd.push_back(24'h500000 + 24'(i));
            send(24'h500000 + 24'(i));
        end
        i_ready = 1'b1;
        drain("wrap");
        chk("wrap_no_ovf", o_overflow, 0);

        // Asynchronous reset between edges with three queued
        i_ready = 1'b0;
        send(24'h000701);
        send(24'h000702);
        send(24'h000703);
        chk("arst_pre_level", o_level, 3);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_empty", o_empty, 1);
        chk("arst_level", o_level, 0);
        chk("arst_reply_data", o_reply_data, 0);
        chk("arst_cmd_data", o_command_data, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (5) begin
            @(negedge i_clk);
            chk("arst_no_cmd", o_command, 0);
        end

        chk("cmd_queue_empty", exp_cmd.size(), 0);
        chk("reply_queue_empty", exp_reply.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
